// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register slice.
//   CTRL_W        : width of the decoded control bundle
//   CTRL_*        : bit positions inside the control bundle
//   REG_ADDR_W    : register-file address width
//   ex_state_e    : EX slot occupancy state (real instruction vs bubble)
package id_ex_stage_pkg;

  localparam int CTRL_W        = 10;
  localparam int REG_ADDR_W    = 5;

  localparam int CTRL_REGWRITE = 9;
  localparam int CTRL_MEMTOREG = 8;
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_BRANCH   = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUOP    = 0;
  localparam int CTRL_ALUOP_W  = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } ex_state_e;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection between the instruction sitting in EX and the
// one being decoded in ID. Purely combinational.
//   ex_valid, ex_mem_read, ex_rt_addr : EX-stage load description
//   id_valid, rs_addr, rt_addr        : ID-stage source registers
//   flush                             : ID instruction is being killed
//   rst                               : synchronous reset (suppresses stall)
//   stall                             : hold PC and IF/ID for one cycle
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt_addr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [REG_ADDR_W-1:0] rt_addr,
  input  logic                  flush,
  input  logic                  rst,
  output logic                  stall
);

  logic hazard;

  // A load targeting $zero never produces a usable value, so it never stalls.
  always_comb begin
    hazard = ex_valid & ex_mem_read & (ex_rt_addr != '0) & id_valid &
             ((ex_rt_addr == rs_addr) | (ex_rt_addr == rt_addr));
  end

  // A flushed instruction needs no operand, so flush overrides the stall.
  assign stall = hazard & ~flush & ~rst;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall insertion.
//   clk, rst            : clock, synchronous active-high reset
//   ID_Valid_In         : ID holds a real instruction
//   Ctrl_In             : decoded control bundle
//   PC_Plus4_In, Rs_Data_In, Rt_Data_In, Ext_Immed_In : ID datapath values
//   Rs_Addr_In, Rt_Addr_In, Rd_Addr_In : instruction register fields
//   Flush_In            : kill the ID instruction (branch/jump)
//   EX_*                : registered ID/EX contents (one-cycle latency)
//   Stall_Out           : combinational hold request to PC and IF/ID
//   Stall_Count_Out     : saturating count of inserted stall cycles
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = id_ex_stage_pkg::CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ID_Valid_In,
  input  logic [CTRL_W-1:0]     Ctrl_In,
  input  logic [DATA_W-1:0]     PC_Plus4_In,
  input  logic [DATA_W-1:0]     Rs_Data_In,
  input  logic [DATA_W-1:0]     Rt_Data_In,
  input  logic [DATA_W-1:0]     Ext_Immed_In,
  input  logic [REG_ADDR_W-1:0] Rs_Addr_In,
  input  logic [REG_ADDR_W-1:0] Rt_Addr_In,
  input  logic [REG_ADDR_W-1:0] Rd_Addr_In,
  input  logic                  Flush_In,
  output logic                  EX_Valid_Out,
  output logic [CTRL_W-1:0]     EX_Ctrl_Out,
  output logic [DATA_W-1:0]     EX_PC_Plus4_Out,
  output logic [DATA_W-1:0]     EX_Rs_Data_Out,
  output logic [DATA_W-1:0]     EX_Rt_Data_Out,
  output logic [DATA_W-1:0]     EX_Immed_Out,
  output logic [REG_ADDR_W-1:0] EX_Rs_Addr_Out,
  output logic [REG_ADDR_W-1:0] EX_Rt_Addr_Out,
  output logic [REG_ADDR_W-1:0] EX_Write_Reg_Out,
  output logic                  Stall_Out,
  output logic [CNT_W-1:0]      Stall_Count_Out
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  ex_state_e                    state_q, state_d;
  logic                         stall_p0;
  logic                         bubble_p0;
  logic                         vld_d;
  logic [CTRL_W-1:0]            ctrl_d;
  logic [REG_ADDR_W-1:0]        wr_d;

  logic                         vld_p1;
  logic [CTRL_W-1:0]            ctrl_p1;
  logic signed [DATA_W-1:0]     pc4_p1;
  logic signed [DATA_W-1:0]     rs_data_p1;
  logic signed [DATA_W-1:0]     rt_data_p1;
  logic signed [DATA_W-1:0]     imm_p1;
  logic [REG_ADDR_W-1:0]        rs_addr_p1;
  logic [REG_ADDR_W-1:0]        rt_addr_p1;
  logic [REG_ADDR_W-1:0]        wr_p1;
  logic [CNT_W-1:0]             stall_cnt;

  // ---- ID stage (p0): hazard check and bubble decision ----
  hazard_detect u_hazard_detect (
    .ex_valid    (vld_p1),
    .ex_mem_read (ctrl_p1[CTRL_MEMREAD]),
    .ex_rt_addr  (rt_addr_p1),
    .id_valid    (ID_Valid_In),
    .rs_addr     (Rs_Addr_In),
    .rt_addr     (Rt_Addr_In),
    .flush       (Flush_In),
    .rst         (rst),
    .stall       (stall_p0)
  );

  assign bubble_p0 = Flush_In | stall_p0 | ~ID_Valid_In;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (bubble_p0)  state_d = ST_BUBBLE;
      ST_BUBBLE: if (!bubble_p0) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Only the next state decides whether EX receives a live instruction.
  always_comb begin
    vld_d  = 1'b0;
    ctrl_d = '0;
    wr_d   = '0;
    if (state_d == ST_RUN) begin
      vld_d  = 1'b1;
      ctrl_d = Ctrl_In;
      wr_d   = Ctrl_In[CTRL_REGDST] ? Rd_Addr_In : Rt_Addr_In;
    end
  end

  // ---- EX stage (p1): ID/EX register ----
  // Data fields load every cycle; in a bubble they are don't-care because
  // valid and control are zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      wr_p1      <= '0;
      pc4_p1     <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      rs_addr_p1 <= '0;
      rt_addr_p1 <= '0;
    end else begin
      vld_p1     <= vld_d;
      ctrl_p1    <= ctrl_d;
      wr_p1      <= wr_d;
      pc4_p1     <= PC_Plus4_In;
      rs_data_p1 <= Rs_Data_In;
      rt_data_p1 <= Rt_Data_In;
      imm_p1     <= Ext_Immed_In;
      rs_addr_p1 <= Rs_Addr_In;
      rt_addr_p1 <= Rt_Addr_In;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           stall_cnt <= '0;
    else if (stall_p0) stall_cnt <= sat_inc(stall_cnt);
  end

  assign EX_Valid_Out     = vld_p1;
  assign EX_Ctrl_Out      = ctrl_p1;
  assign EX_PC_Plus4_Out  = pc4_p1;
  assign EX_Rs_Data_Out   = rs_data_p1;
  assign EX_Rt_Data_Out   = rt_data_p1;
  assign EX_Immed_Out     = imm_p1;
  assign EX_Rs_Addr_Out   = rs_addr_p1;
  assign EX_Rt_Addr_Out   = rt_addr_p1;
  assign EX_Write_Reg_Out = wr_p1;
  assign Stall_Out        = stall_p0;
  assign Stall_Count_Out  = stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (counter narrowed to 4 bits so saturation
// is reachable quickly).
module tb_id_ex_stage;

  localparam logic [9:0] CTRL_LW  = 10'h390; // RegWrite,MemtoReg,MemRead,ALUSrc
  localparam logic [9:0] CTRL_R   = 10'h20A; // RegWrite,RegDst,ALUOp=010
  localparam logic [9:0] CTRL_RNR = 10'h202; // as CTRL_R but RegDst=0

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid_In;
  logic [9:0]  Ctrl_In;
  logic [31:0] PC_Plus4_In, Rs_Data_In, Rt_Data_In, Ext_Immed_In;
  logic [4:0]  Rs_Addr_In, Rt_Addr_In, Rd_Addr_In;
  logic        Flush_In;
  logic        EX_Valid_Out;
  logic [9:0]  EX_Ctrl_Out;
  logic [31:0] EX_PC_Plus4_Out, EX_Rs_Data_Out, EX_Rt_Data_Out, EX_Immed_Out;
  logic [4:0]  EX_Rs_Addr_Out, EX_Rt_Addr_Out, EX_Write_Reg_Out;
  logic        Stall_Out;
  logic [3:0]  Stall_Count_Out;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage #(.DATA_W(32), .CTRL_W(10), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .ID_Valid_In      (ID_Valid_In),
    .Ctrl_In          (Ctrl_In),
    .PC_Plus4_In      (PC_Plus4_In),
    .Rs_Data_In       (Rs_Data_In),
    .Rt_Data_In       (Rt_Data_In),
    .Ext_Immed_In     (Ext_Immed_In),
    .Rs_Addr_In       (Rs_Addr_In),
    .Rt_Addr_In       (Rt_Addr_In),
    .Rd_Addr_In       (Rd_Addr_In),
    .Flush_In         (Flush_In),
    .EX_Valid_Out     (EX_Valid_Out),
    .EX_Ctrl_Out      (EX_Ctrl_Out),
    .EX_PC_Plus4_Out  (EX_PC_Plus4_Out),
    .EX_Rs_Data_Out   (EX_Rs_Data_Out),
    .EX_Rt_Data_Out   (EX_Rt_Data_Out),
    .EX_Immed_Out     (EX_Immed_Out),
    .EX_Rs_Addr_Out   (EX_Rs_Addr_Out),
    .EX_Rt_Addr_Out   (EX_Rt_Addr_Out),
    .EX_Write_Reg_Out (EX_Write_Reg_Out),
    .Stall_Out        (Stall_Out),
    .Stall_Count_Out  (Stall_Count_Out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [9:0] c, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic fl);
    ID_Valid_In = v;
    Ctrl_In     = c;
    Rs_Addr_In  = rs;
    Rt_Addr_In  = rt;
    Rd_Addr_In  = rd;
    Flush_In    = fl;
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    ID_Valid_In  = 1'b1;
    Ctrl_In      = 10'($urandom);
    PC_Plus4_In  = $urandom;
    Rs_Data_In   = $urandom;
    Rt_Data_In   = $urandom;
    Ext_Immed_In = $urandom;
    Rs_Addr_In   = 5'($urandom);
    Rt_Addr_In   = 5'($urandom);
    Rd_Addr_In   = 5'($urandom);
    Flush_In     = 1'b0;
    tick;
    tick;
    vectors++; if (Stall_Out !== 1'b0) begin miscompares++; $display("FAIL rst_stall got %0h want 0", Stall_Out); end
    vectors++; if (EX_Valid_Out !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0h want 0", EX_Valid_Out); end
    vectors++; if (EX_Ctrl_Out !== 10'h0) begin miscompares++; $display("FAIL rst_ctrl got %0h want 0", EX_Ctrl_Out); end
    vectors++; if (EX_PC_Plus4_Out !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %0h want 0", EX_PC_Plus4_Out); end
    vectors++; if (EX_Rs_Data_Out !== 32'h0) begin miscompares++; $display("FAIL rst_rsd got %0h want 0", EX_Rs_Data_Out); end
    vectors++; if (EX_Rt_Data_Out !== 32'h0) begin miscompares++; $display("FAIL rst_rtd got %0h want 0", EX_Rt_Data_Out); end
    vectors++; if (EX_Immed_Out !== 32'h0) begin miscompares++; $display("FAIL rst_imm got %0h want 0", EX_Immed_Out); end
    vectors++; if (EX_Rs_Addr_Out !== 5'h0) begin miscompares++; $display("FAIL rst_rsa got %0h want 0", EX_Rs_Addr_Out); end
    vectors++; if (EX_Rt_Addr_Out !== 5'h0) begin miscompares++; $display("FAIL rst_rta got %0h want 0", EX_Rt_Addr_Out); end
    vectors++; if (EX_Write_Reg_Out !== 5'h0) begin miscompares++; $display("FAIL rst_wr got %0h want 0", EX_Write_Reg_Out); end
    vectors++; if (Stall_Count_Out !== 4'h0) begin miscompares++; $display("FAIL rst_cnt got %0h want 0", Stall_Count_Out); end
    rst = 1'b0;
  endtask

  task automatic test_pass_through;
    set_id(1'b1, CTRL_R, 5'd2, 5'd3, 5'd8, 1'b0);
    Ext_Immed_In = 32'hFFFFFFFF;
    Rs_Data_In   = 32'h00001234;
    Rt_Data_In   = 32'h00005678;
    PC_Plus4_In  = 32'h00000104;
    #1;
    vectors++; if (Stall_Out !== 1'b0) begin miscompares++; $display("FAIL pt_stall got %0h want 0", Stall_Out); end
    tick;
    vectors++; if (EX_Immed_Out !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL pt_imm got %0h want ffffffff", EX_Immed_Out); end
    vectors++; if (EX_Rs_Data_Out !== 32'h00001234) begin miscompares++; $display("FAIL pt_rsd got %0h want 1234", EX_Rs_Data_Out); end
    vectors++; if (EX_Rt_Data_Out !== 32'h00005678) begin miscompares++; $display("FAIL pt_rtd got %0h want 5678", EX_Rt_Data_Out); end
    vectors++; if (EX_PC_Plus4_Out !== 32'h00000104) begin miscompares++; $display("FAIL pt_pc got %0h want 104", EX_PC_Plus4_Out); end
    vectors++; if (EX_Write_Reg_Out !== 5'd8) begin miscompares++; $display("FAIL pt_wr got %0d want 8", EX_Write_Reg_Out); end
    vectors++; if (EX_Valid_Out !== 1'b1) begin miscompares++; $display("FAIL pt_valid got %0h want 1", EX_Valid_Out); end
    vectors++; if (EX_Ctrl_Out !== CTRL_R) begin miscompares++; $display("FAIL pt_ctrl got %0h want %0h", EX_Ctrl_Out, CTRL_R); end
    vectors++; if (EX_Rs_Addr_Out !== 5'd2) begin miscompares++; $display("FAIL pt_rsa got %0d want 2", EX_Rs_Addr_Out); end
    vectors++; if (EX_Rt_Addr_Out !== 5'd3) begin miscompares++; $display("FAIL pt_rta got %0d want 3", EX_Rt_Addr_Out); end
    // RegDst=0 selects the rt field as destination
    set_id(1'b1, CTRL_RNR, 5'd2, 5'd3, 5'd8, 1'b0);
    tick;
    vectors++; if (EX_Write_Reg_Out !== 5'd3) begin miscompares++; $display("FAIL pt_wr_rt got %0d want 3", EX_Write_Reg_Out); end
  endtask

  task automatic test_no_false_hazard;
    set_id(1'b1, CTRL_LW, 5'd1, 5'd0, 5'd0, 1'b0);
    tick;
    set_id(1'b1, CTRL_R, 5'd0, 5'd4, 5'd5, 1'b0);
    #1;
    vectors++; if (Stall_Out !== 1'b0) begin miscompares++; $display("FAIL nf_zero got %0h want 0", Stall_Out); end
    tick;
    set_id(1'b1, CTRL_R, 5'd1, 5'd9, 5'd10, 1'b0);
    tick;
    set_id(1'b1, CTRL_R, 5'd9, 5'd9, 5'd11, 1'b0);
    #1;
    vectors++; if (Stall_Out !== 1'b0) begin miscompares++; $display("FAIL nf_nonload got %0h want 0", Stall_Out); end
    tick;
    vectors++; if (EX_Valid_Out !== 1'b1) begin miscompares++; $display("FAIL nf_valid got %0h want 1", EX_Valid_Out); end
    // load in EX, but ID slot empty: no stall, EX gets a bubble
    set_id(1'b1, CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    tick;
    set_id(1'b0, CTRL_R, 5'd9, 5'd2, 5'd3, 1'b0);
    #1;
    vectors++; if (Stall_Out !== 1'b0) begin miscompares++; $display("FAIL nf_idinv got %0h want 0", Stall_Out); end
    tick;
    vectors++; if (EX_Valid_Out !== 1'b0) begin miscompares++; $display("FAIL nf_bub_valid got %0h want 0", EX_Valid_Out); end
    vectors++; if (EX_Ctrl_Out !== 10'h0) begin miscompares++; $display("FAIL nf_bub_ctrl got %0h want 0", EX_Ctrl_Out); end
    vectors++; if (EX_Write_Reg_Out !== 5'h0) begin miscompares++; $display("FAIL nf_bub_wr got %0h want 0", EX_Write_Reg_Out); end
    vectors++; if (Stall_Count_Out !== 4'd0) begin miscompares++; $display("FAIL nf_cnt got %0d want 0", Stall_Count_Out); end
  endtask

  task automatic test_load_use;
    set_id(1'b1, CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    tick;
    vectors++; if (EX_Ctrl_Out !== CTRL_LW) begin miscompares++; $display("FAIL lu_ctrl got %0h want %0h", EX_Ctrl_Out, CTRL_LW); end
    vectors++; if (EX_Write_Reg_Out !== 5'd9) begin miscompares++; $display("FAIL lu_wr got %0d want 9", EX_Write_Reg_Out); end
    set_id(1'b1, CTRL_R, 5'd9, 5'd2, 5'd12, 1'b0);
    #1;
    vectors++; if (Stall_Out !== 1'b1) begin miscompares++; $display("FAIL lu_stall got %0h want 1", Stall_Out); end
    tick;
    vectors++; if (EX_Valid_Out !== 1'b0) begin miscompares++; $display("FAIL lu_bub_valid got %0h want 0", EX_Valid_Out); end
    vectors++; if (EX_Ctrl_Out !== 10'h0) begin miscompares++; $display("FAIL lu_bub_ctrl got %0h want 0", EX_Ctrl_Out); end
    vectors++; if (Stall_Out !== 1'b0) begin miscompares++; $display("FAIL lu_clear got %0h want 0", Stall_Out); end
    vectors++; if (Stall_Count_Out !== 4'd1) begin miscompares++; $display("FAIL lu_cnt got %0d want 1", Stall_Count_Out); end
    tick;
    vectors++; if (EX_Valid_Out !== 1'b1) begin miscompares++; $display("FAIL lu_resume_valid got %0h want 1", EX_Valid_Out); end
    vectors++; if (EX_Write_Reg_Out !== 5'd12) begin miscompares++; $display("FAIL lu_resume_wr got %0d want 12", EX_Write_Reg_Out); end
    // hazard through the rt field
    set_id(1'b1, CTRL_LW, 5'd3, 5'd9, 5'd0, 1'b0);
    tick;
    set_id(1'b1, CTRL_R, 5'd4, 5'd9, 5'd13, 1'b0);
    #1;
    vectors++; if (Stall_Out !== 1'b1) begin miscompares++; $display("FAIL lu_rt_stall got %0h want 1", Stall_Out); end
    tick;
    vectors++; if (Stall_Count_Out !== 4'd2) begin miscompares++; $display("FAIL lu_rt_cnt got %0d want 2", Stall_Count_Out); end
  endtask

  task automatic test_flush_priority;
    set_id(1'b1, CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    tick;
    set_id(1'b1, CTRL_R, 5'd9, 5'd2, 5'd12, 1'b1);
    #1;
    vectors++; if (Stall_Out !== 1'b0) begin miscompares++; $display("FAIL fl_stall got %0h want 0", Stall_Out); end
    tick;
    vectors++; if (EX_Ctrl_Out !== 10'h0) begin miscompares++; $display("FAIL fl_ctrl got %0h want 0", EX_Ctrl_Out); end
    vectors++; if (EX_Valid_Out !== 1'b0) begin miscompares++; $display("FAIL fl_valid got %0h want 0", EX_Valid_Out); end
    vectors++; if (Stall_Count_Out !== 4'd2) begin miscompares++; $display("FAIL fl_cnt got %0d want 2", Stall_Count_Out); end
  endtask

  task automatic test_saturation;
    int exp_cnt;
    exp_cnt = 2;
    for (int i = 0; i < 20; i++) begin
      set_id(1'b1, CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b0);
      tick;
      set_id(1'b1, CTRL_R, 5'd9, 5'd2, 5'd12, 1'b0);
      #1;
      vectors++; if (Stall_Out !== 1'b1) begin miscompares++; $display("FAIL sat_stall[%0d] got %0h want 1", i, Stall_Out); end
      tick;
      exp_cnt = (exp_cnt >= 15) ? 15 : exp_cnt + 1;
      vectors++; if (Stall_Count_Out !== 4'(exp_cnt)) begin miscompares++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, Stall_Count_Out, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid_stall;
    set_id(1'b1, CTRL_LW, 5'd1, 5'd9, 5'd0, 1'b0);
    tick;
    set_id(1'b1, CTRL_R, 5'd9, 5'd2, 5'd12, 1'b0);
    #1;
    vectors++; if (Stall_Out !== 1'b1) begin miscompares++; $display("FAIL rms_pre got %0h want 1", Stall_Out); end
    rst = 1'b1;
    #1;
    vectors++; if (Stall_Out !== 1'b0) begin miscompares++; $display("FAIL rms_stall got %0h want 0", Stall_Out); end
    tick;
    vectors++; if (Stall_Count_Out !== 4'd0) begin miscompares++; $display("FAIL rms_cnt got %0d want 0", Stall_Count_Out); end
    vectors++; if (EX_Valid_Out !== 1'b0) begin miscompares++; $display("FAIL rms_valid got %0h want 0", EX_Valid_Out); end
    rst = 1'b0;
    tick;
    vectors++; if (EX_Valid_Out !== 1'b1) begin miscompares++; $display("FAIL rms_resume got %0h want 1", EX_Valid_Out); end
    vectors++; if (EX_Write_Reg_Out !== 5'd12) begin miscompares++; $display("FAIL rms_wr got %0d want 12", EX_Write_Reg_Out); end
  endtask

  initial begin
    test_reset;
    test_pass_through;
    test_no_false_hazard;
    test_load_use;
    test_flush_priority;
    test_saturation;
    test_reset_mid_stall;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width of operands, PC+4 and extended immediate.
REQ-002 Parameter CTRL_W, default 10, control bundle width {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, ALUOp[2:0]} (bit 9 down to 0).
REQ-003 Parameter CNT_W, default 16, stall counter width.
REQ-004 One clock; reset is synchronous and active-high: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 ID_Valid_In  in  1  ID stage holds a real instruction.
REQ-006 Ctrl_In  in  CTRL_W  decoded control bundle.
REQ-007 PC_Plus4_In  in  DATA_W  PC+4 of ID instruction.
REQ-008 Rs_Data_In, Rt_Data_In  in  DATA_W each  register-file read data.
REQ-009 Ext_Immed_In  in  DATA_W  sign-extended immediate from the sign-extension unit.
REQ-010 Rs_Addr_In, Rt_Addr_In, Rd_Addr_In  in  5 each  instruction register fields.
REQ-011 Flush_In  in  1  branch/jump kill of the ID instruction.
REQ-012 EX_Valid_Out  out  1; EX_Ctrl_Out  out  CTRL_W; EX_PC_Plus4_Out, EX_Rs_Data_Out, EX_Rt_Data_Out, EX_Immed_Out  out  DATA_W; EX_Rs_Addr_Out, EX_Rt_Addr_Out, EX_Write_Reg_Out  out  5: registered ID/EX contents.
REQ-013 Stall_Out  out  1  combinational load-use stall to PC and IF/ID register (hold).
REQ-014 Stall_Count_Out  out  CNT_W  count of stall cycles inserted.

Function
REQ-015 All EX_* outputs SHALL update only on rising clk; one-cycle latency ID->EX.
REQ-016 Load-use hazard SHALL be: EX_Valid_Out & EX_Ctrl_Out.MemRead & EX_Rt_Addr_Out!=0 & ID_Valid_In & (EX_Rt_Addr_Out==Rs_Addr_In | EX_Rt_Addr_Out==Rt_Addr_In).
REQ-017 Stall_Out SHALL equal hazard & !Flush_In & !rst.
REQ-018 Bubble cycle (Flush_In or Stall_Out or !ID_Valid_In): EX_Valid_Out<=0, EX_Ctrl_Out<=0; data/address registers SHALL still load inputs (don't-care contents).
REQ-019 Normal cycle: all inputs latched, EX_Valid_Out<=1.
REQ-020 EX_Write_Reg_Out SHALL latch Rd_Addr_In when Ctrl_In.RegDst=1, else Rt_Addr_In; 0 in bubble.
REQ-021 Flush_In SHALL take priority over hazard; simultaneous flush+hazard yields bubble with Stall_Out=0.
REQ-022 Stall_Count_Out SHALL increment by 1 on each clock where Stall_Out=1, saturating at all-ones (no wrap).
REQ-023 A stall SHALL last exactly one cycle per load: next cycle EX holds bubble so hazard clears.
REQ-024 Internal state machine SHALL track two states, RUN and BUBBLE (BUBBLE entered on any bubble cycle, left on next normal cycle); state exposed only through EX_Valid_Out.

Reset
REQ-025 On rst=1 at a clock edge: all EX_* outputs, Stall_Count_Out and state SHALL become 0/RUN regardless of other inputs.
REQ-026 Reset mid-stall SHALL cancel the stall; Stall_Out=0 while rst=1; the stall counter does not increment during reset.

Structure
REQ-027 Shared package SHALL hold CTRL_W, control-bit index constants (CTRL_REGWRITE..CTRL_ALUOP), and REG_ADDR_W=5.
REQ-028 One sub-module, hazard_detect, SHALL implement REQ-016/017 combinationally; the pipeline register and counter live in id_ex_stage.

Verification
REQ-029 Reset: rst=1 two cycles with random inputs -> all EX_* =0, Stall_Count_Out=0, Stall_Out=0.
REQ-030 Pass-through: Ext_Immed_In=32'hFFFFFFFF, Rs_Data_In=32'h00001234, RegDst=1, Rd=5'd8 -> next cycle EX_Immed_Out=32'hFFFFFFFF, EX_Rs_Data_Out=32'h00001234, EX_Write_Reg_Out=8, EX_Valid_Out=1.
REQ-031 Load-use: lw into Rt=9 latched, then ID instr Rs=9 -> Stall_Out=1 that cycle, next EX_Valid_Out=0, Stall_Out=0, Stall_Count_Out=1.
REQ-032 No false hazard: EX load with Rt=0 and ID Rs=0 -> Stall_Out=0; EX non-load Rt=9, ID Rs=9 -> Stall_Out=0.
REQ-033 Flush priority: hazard conditions plus Flush_In=1 -> Stall_Out=0, next EX_Ctrl_Out=0, counter unchanged.
REQ-034 Saturation: CNT_W=4, force 20 load-use stalls -> Stall_Count_Out stays 4'hF.
